// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [XLEN-1:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/if_resp_buffer.sv
// One-entry holding register for a fetch response that decode could not take yet.
module if_resp_buffer
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            drain,
  input  logic            flush,
  input  logic [XLEN-1:0] d_instr,
  input  logic [XLEN-1:0] d_pc,
  output logic            buf_valid,
  output logic [XLEN-1:0] buf_instr,
  output logic [XLEN-1:0] buf_pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_instr <= NOP_INSTR;
      buf_pc    <= '0;
    end else if (flush || drain) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_instr <= d_instr;
      buf_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, keeps one imem read in flight and feeds the IF/ID register.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jumpif,
  input  logic [XLEN-1:0] jumpaddr,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [XLEN-1:0] if_id_instr
);

  fetch_state_t    state, state_nxt;
  logic            kill, kill_nxt;
  logic [XLEN-1:0] pc, inflight_pc, target;
  logic            redirect, issue;
  logic            overlap, deliver, capture, drain;
  logic            buf_valid;
  logic [XLEN-1:0] buf_instr, buf_pc;
  logic            unused_jumpaddr_lsb;

  assign redirect            = jumpif & ~stall;
  assign target              = {jumpaddr[XLEN-1:2], 2'b00};
  assign unused_jumpaddr_lsb = ^jumpaddr[1:0];
  assign imem_addr           = pc;
  assign issue               = imem_req & imem_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
    end
  end

  // A redirect leaves kill set only if a request is still outstanding after this cycle.
  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    case (state)
      S_REQ: begin
        if (issue) begin
          state_nxt = S_WAIT;
          kill_nxt  = redirect;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill) begin
            state_nxt = S_REQ;
            kill_nxt  = 1'b0;
          end else if (stall) begin
            state_nxt = S_FULL;
          end else if (issue) begin
            kill_nxt  = redirect;
          end else begin
            state_nxt = S_REQ;
          end
        end else if (redirect) begin
          kill_nxt = 1'b1;
        end
      end
      S_FULL: begin
        if (!stall) state_nxt = S_REQ;
      end
      default: begin
        state_nxt = S_REQ;
        kill_nxt  = 1'b0;
      end
    endcase
  end

  // The overlap request depends only on stall so jumpif never reaches imem_req.
  always_comb begin
    overlap = 1'b0;
    deliver = 1'b0;
    capture = 1'b0;
    drain   = 1'b0;
    case (state)
      S_WAIT: begin
        deliver = imem_rvalid & ~kill & ~stall;
        capture = imem_rvalid & ~kill & stall;
        overlap = deliver;
      end
      S_FULL:  drain = ~stall & buf_valid;
      default: ;
    endcase
    imem_req = ~rst & ((state == S_REQ) | overlap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_instr <= NOP_INSTR;
    end else begin
      if (redirect)   pc <= target;
      else if (issue) pc <= pc + PC_STEP;
      if (issue) inflight_pc <= pc;
      if (!stall) begin
        if (redirect) begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end else if (deliver) begin
          if_id_valid <= 1'b1;
          if_id_instr <= imem_rdata;
          if_id_pc    <= inflight_pc;
          if_id_pc4   <= inflight_pc + PC_STEP;
        end else if (drain) begin
          if_id_valid <= 1'b1;
          if_id_instr <= buf_instr;
          if_id_pc    <= buf_pc;
          if_id_pc4   <= buf_pc + PC_STEP;
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end
    end
  end

  if_resp_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .drain     (drain),
    .flush     (redirect),
    .d_instr   (imem_rdata),
    .d_pc      (inflight_pc),
    .buf_valid (buf_valid),
    .buf_instr (buf_instr),
    .buf_pc    (buf_pc)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run against a stream-level model.
module tb_if_fetch_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        jumpif;
  logic [31:0] jumpaddr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;

  int checks   = 0;
  int failures = 0;

  // memory model: single outstanding read, fixed latency per grant
  int          lat;
  logic        gnt_en;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rvalid = mem_pend && (mem_cnt == 0);
  assign imem_rdata  = memfn(mem_addr);
  assign imem_gnt    = imem_req && gnt_en && (!mem_pend || (imem_rvalid && lat == 1));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      mem_addr <= 32'h0;
    end else if (imem_req && imem_gnt) begin
      mem_pend <= 1'b1;
      mem_cnt  <= lat - 1;
      mem_addr <= imem_addr;
    end else if (imem_rvalid) begin
      mem_pend <= 1'b0;
    end else if (mem_pend) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .jumpif      (jumpif),
    .jumpaddr    (jumpaddr),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; jumpif = 1'b0; jumpaddr = 32'h0; lat = 1; gnt_en = 1'b1;
    #1;
    repeat (2) step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== IF_RESET_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, IF_RESET_PC); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if ({if_id_pc, if_id_pc4, if_id_instr} !== 96'h0) begin failures++;
      $display("FAIL reset_ifid got=%h/%h/%h exp=0/0/0", if_id_pc, if_id_pc4, if_id_instr); end
  endtask

  task automatic test_straight;
    logic [31:0] e;
    rst = 1'b0;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      e = 32'(4 * i);
      checks++; if (!(if_id_valid === 1'b1 && if_id_pc === e && if_id_pc4 === e + 32'd4 && if_id_instr === memfn(e))) begin
        failures++; $display("FAIL straight_%0d got v=%b pc=%h pc4=%h ins=%h exp pc=%h", i, if_id_valid, if_id_pc, if_id_pc4, if_id_instr, e); end
    end
  endtask

  task automatic test_stall;
    int n;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'd12 && if_id_instr === memfn(32'd12))) begin
        failures++; $display("FAIL stall_hold_%0d got v=%b pc=%h exp pc=0000000c", k, if_id_valid, if_id_pc); end
      checks++; if (dut.state !== S_FULL) begin failures++; $display("FAIL stall_state_%0d got=%0d exp=%0d", k, dut.state, S_FULL); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req_%0d got=%b exp=0", k, imem_req); end
    end
    stall = 1'b0;
    step();
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'd16 && if_id_instr === memfn(32'd16))) begin
      failures++; $display("FAIL stall_drain got v=%b pc=%h ins=%h exp pc=00000010", if_id_valid, if_id_pc, if_id_instr); end
    n = 0;
    do begin step(); n++; end while (!if_id_valid && n < 8);
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'd20)) begin
      failures++; $display("FAIL stall_next got v=%b pc=%h exp pc=00000014", if_id_valid, if_id_pc); end
    step();
  endtask

  task automatic test_redirect;
    int n, bub;
    jumpif = 1'b1; jumpaddr = 32'h0000_0103;
    step();
    jumpif = 1'b0;
    checks++; if (!(if_id_valid === 1'b0 && if_id_instr === NOP_INSTR)) begin
      failures++; $display("FAIL redir_squash got v=%b ins=%h exp v=0 ins=0", if_id_valid, if_id_instr); end
    n = 0; bub = 0;
    do begin step(); n++; if (!if_id_valid) bub++; end while (!if_id_valid && n < 10);
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'h100 && if_id_instr === memfn(32'h100))) begin
      failures++; $display("FAIL redir_target got v=%b pc=%h exp pc=00000100", if_id_valid, if_id_pc); end
    checks++; if (bub !== 2) begin failures++; $display("FAIL redir_bubbles got=%0d exp=2", bub); end
    step();
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'h104)) begin
      failures++; $display("FAIL redir_follow got v=%b pc=%h exp pc=00000104", if_id_valid, if_id_pc); end
  endtask

  task automatic test_jump_stall;
    int n;
    logic [31:0] hold_instr;
    hold_instr = memfn(32'h104);
    stall = 1'b1; jumpif = 1'b1; jumpaddr = 32'h0000_0200;
    step();
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'h104 && if_id_instr === hold_instr)) begin
      failures++; $display("FAIL jstall_hold got v=%b pc=%h exp pc=00000104", if_id_valid, if_id_pc); end
    checks++; if (imem_addr !== 32'h10C) begin failures++; $display("FAIL jstall_pc got=%h exp=0000010c", imem_addr); end
    stall = 1'b0;
    step();
    jumpif = 1'b0;
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL jstall_squash got=%b exp=0", if_id_valid); end
    n = 0;
    do begin step(); n++; end while (!if_id_valid && n < 10);
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'h200 && if_id_instr === memfn(32'h200))) begin
      failures++; $display("FAIL jstall_target got v=%b pc=%h exp pc=00000200", if_id_valid, if_id_pc); end
    step();
  endtask

  task automatic test_wrap;
    int n;
    jumpif = 1'b1; jumpaddr = 32'hFFFF_FFF9;
    step();
    jumpif = 1'b0;
    n = 0;
    do begin step(); n++; end while (!if_id_valid && n < 10);
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'hFFFF_FFF8 && if_id_pc4 === 32'hFFFF_FFFC)) begin
      failures++; $display("FAIL wrap_a got v=%b pc=%h pc4=%h exp fffffff8/fffffffc", if_id_valid, if_id_pc, if_id_pc4); end
    step();
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'hFFFF_FFFC && if_id_pc4 === 32'h0)) begin
      failures++; $display("FAIL wrap_b got v=%b pc=%h pc4=%h exp fffffffc/00000000", if_id_valid, if_id_pc, if_id_pc4); end
    step();
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'h0 && if_id_instr === memfn(32'h0))) begin
      failures++; $display("FAIL wrap_c got v=%b pc=%h exp pc=00000000", if_id_valid, if_id_pc); end
  endtask

  task automatic test_latency3;
    int first, last, pulses;
    logic [31:0] e;
    rst = 1'b1; lat = 3;
    step();
    rst = 1'b0;
    first = -1; last = 0; pulses = 0; e = IF_RESET_PC;
    for (int c = 0; c < 24; c++) begin
      step();
      checks++; if (mem_pend && !imem_rvalid && imem_req !== 1'b0) begin
        failures++; $display("FAIL lat3_req_in_wait cyc=%0d got=%b exp=0", c, imem_req); end
      if (if_id_valid) begin
        pulses++;
        checks++; if (if_id_pc !== e) begin failures++; $display("FAIL lat3_pc got=%h exp=%h", if_id_pc, e); end
        e = e + 32'd4;
        if (first >= 0) begin
          checks++; if (c - last !== 4) begin failures++; $display("FAIL lat3_period got=%0d exp=4", c - last); end
        end else first = c;
        last = c;
      end
    end
    checks++; if (pulses !== 6) begin failures++; $display("FAIL lat3_pulses got=%0d exp=6", pulses); end
  endtask

  task automatic test_reset_mid_wait;
    int n;
    n = 0;
    while (!(mem_pend && !imem_rvalid) && n < 8) begin step(); n++; end
    checks++; if (!(mem_pend && !imem_rvalid)) begin failures++; $display("FAIL rstwait_setup got pend=%b exp=1", mem_pend); end
    rst = 1'b1;
    #1;
    checks++; if (!(imem_req === 1'b0 && imem_addr === IF_RESET_PC)) begin
      failures++; $display("FAIL rstwait_mem got req=%b addr=%h exp 0/%h", imem_req, imem_addr, IF_RESET_PC); end
    checks++; if (!(if_id_valid === 1'b0 && if_id_instr === NOP_INSTR)) begin
      failures++; $display("FAIL rstwait_ifid got v=%b ins=%h exp 0/0", if_id_valid, if_id_instr); end
    step();
    lat = 1; rst = 1'b0;
    step(); step();
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === IF_RESET_PC && if_id_instr === memfn(IF_RESET_PC))) begin
      failures++; $display("FAIL rstwait_first got v=%b pc=%h exp pc=%h", if_id_valid, if_id_pc, IF_RESET_PC); end
    step();
    checks++; if (!(if_id_valid === 1'b1 && if_id_pc === 32'd4)) begin
      failures++; $display("FAIL rstwait_second got v=%b pc=%h exp pc=00000004", if_id_valid, if_id_pc); end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, p_pc, p_instr, p_tgt;
    logic        p_valid, p_stall, p_redir;
    int          idle;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_pc = IF_RESET_PC; idle = 0;
    for (int c = 0; c < 2000; c++) begin
      stall    = ($urandom % 4) == 0;
      jumpif   = ($urandom % 12) == 0;
      jumpaddr = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : 32'($urandom);
      gnt_en   = ($urandom % 4) != 0;
      lat      = 1 + int'($urandom % 3);
      p_valid = if_id_valid; p_pc = if_id_pc; p_instr = if_id_instr;
      p_stall = stall; p_redir = jumpif && !stall; p_tgt = {jumpaddr[31:2], 2'b00};
      step();
      if (p_stall) begin
        checks++; if (!(if_id_valid === p_valid && if_id_pc === p_pc && if_id_instr === p_instr)) begin
          failures++; $display("FAIL rnd_hold cyc=%0d got v=%b pc=%h exp v=%b pc=%h", c, if_id_valid, if_id_pc, p_valid, p_pc); end
      end else if (p_redir) begin
        checks++; if (!(if_id_valid === 1'b0 && if_id_instr === NOP_INSTR)) begin
          failures++; $display("FAIL rnd_squash cyc=%0d got v=%b ins=%h exp 0/0", c, if_id_valid, if_id_instr); end
        exp_pc = p_tgt; idle = 0;
      end else if (if_id_valid) begin
        checks++; if (!(if_id_pc === exp_pc && if_id_pc4 === exp_pc + 32'd4 && if_id_instr === memfn(exp_pc))) begin
          failures++; $display("FAIL rnd_deliver cyc=%0d got pc=%h pc4=%h ins=%h exp pc=%h", c, if_id_pc, if_id_pc4, if_id_instr, exp_pc); end
        exp_pc = exp_pc + 32'd4; idle = 0;
      end else begin
        checks++; if (if_id_instr !== NOP_INSTR) begin failures++; $display("FAIL rnd_bubble cyc=%0d got ins=%h exp 0", c, if_id_instr); end
        idle++;
      end
      checks++; if (idle >= 40) begin failures++; $display("FAIL rnd_progress cyc=%0d idle=%0d exp <40", c, idle); idle = 0; end
      checks++; if (mem_pend && !imem_rvalid && imem_req !== 1'b0) begin
        failures++; $display("FAIL rnd_outstanding cyc=%0d got req=%b exp 0", c, imem_req); end
    end
    stall = 1'b0; jumpif = 1'b0; gnt_en = 1'b1; lat = 1;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_redirect();
    test_jump_stall();
    test_wrap();
    test_latency3();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC, issues one instruction-memory read at a time, and loads the IF/ID pipeline register consumed by decode. It takes the ID-stage redirect (`jumpif`/`jumpaddr`) and the hazard-unit `stall`. Branches and jumps have no delay slot: on a redirect, every younger fetch is squashed.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `jumpif` in 1: redirect request from ID, valid only when `stall`=0.
- `jumpaddr` in 32: redirect target; bits [1:0] are forced to 0.
- `stall` in 1: ID cannot accept; hold IF/ID.
- `imem_req` out 1: read request.
- `imem_addr` out 32: word-aligned read address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid, one or more cycles after grant.
- `imem_rdata` in 32: instruction word.
- `if_id_valid` out 1: IF/ID holds a live instruction.
- `if_id_pc` out 32: PC of that instruction.
- `if_id_pc4` out 32: `if_id_pc`+4.
- `if_id_instr` out 32: instruction; 32'h0 (NOP) when not valid.

## Operation
- Registers:
  - `pc`: next address to request.
  - `state` ∈ {REQ, WAIT, FULL}.
  - `kill`: marks the in-flight response as stale.
  - 1-entry response buffer (`buf_instr`, `buf_pc`).
  - `inflight_pc`.
  - IF/ID register.
- Only one memory request is outstanding at a time.
- REQ:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_gnt`: `inflight_pc`<=`pc`, `pc`<=`pc`+4, go to WAIT.
- WAIT: `imem_req`=0, except for the overlap issue below.
  - On `imem_rvalid` with `kill`=1: drop the data, clear `kill`, go to REQ.
  - On `imem_rvalid` with `kill`=0 and IF/ID accepting (`stall`=0): load IF/ID with (`imem_rdata`, `inflight_pc`, valid=1).
    - Overlap issue: in that same cycle drive `imem_req`=1 with `imem_addr`=`pc`.
    - If granted: `inflight_pc`<=`pc`, `pc`<=`pc`+4, stay in WAIT.
    - If not granted: go to REQ.
  - On `imem_rvalid` with `kill`=0 and `stall`=1: capture the data into the buffer, go to FULL.
- FULL:
  - `imem_req`=0.
  - When `stall`=0: move the buffer into IF/ID (valid=1), go to REQ.
- IF/ID register:
  - Holds its contents while `stall`=1.
  - When `stall`=0 and no new instruction is available, loads a bubble (valid=0, instr=0).
- Redirect, effective only when `jumpif`=1 and `stall`=0:
  - `pc`<=`{jumpaddr[31:2],2'b00}`.
  - IF/ID loads a bubble.
  - Buffer is discarded; FULL goes to REQ.
  - In WAIT, or in REQ with a same-cycle grant: `kill`<=1 and state goes to WAIT. The response that arrives later is discarded.
  - A redirect overrides any same-cycle delivery into IF/ID.
- `jumpif` while `stall`=1 is ignored. ID re-asserts it once the stall clears.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `state`=REQ, `kill`=0.
  - `imem_req` is not asserted while `rst` is high.
  - `imem_addr`=`RESET_PC`.
  - `if_id_valid`=0; `if_id_pc`=0, `if_id_pc4`=0, `if_id_instr`=0.
- Memory with same-cycle grant and rvalid one cycle later:
  - First instruction reaches IF/ID 2 cycles after reset release.
  - Sustained throughput is 1 instruction/cycle.
- Redirect asserted at edge N: `imem_addr`=`jumpaddr` no later than the first REQ/overlap cycle after the stale response retires.
- Redirect penalty with zero-wait memory: 2 bubbles.
- Reset mid-WAIT: the outstanding response is ignored after reset. `kill` is set out of reset only if the memory can still return it (system-level; the memory is reset too).
- No combinational path from `jumpif` or `stall` to `imem_req`, except the overlap term, which depends only on `stall`.

## Structure
- Shared package `if_pkg`:
  - `fetch_state_t` enum.
  - `NOP_INSTR`=32'h0.
  - `RESET_PC` default.
- One sub-module, `if_resp_buffer`: the 1-entry holding register with load/drain/flush controls.
- FSM, PC and IF/ID register live in the top module.

## Test plan
- Reset, zero-wait memory, straight-line code: `if_id_pc` sequence is 0, 4, 8, 12 on consecutive cycles, starting 2 cycles after reset release.
- `stall`=1 for 3 cycles while a response arrives:
  - state goes to FULL.
  - IF/ID is held.
  - After the stall, the buffered instr appears with the correct PC.
  - No PC is skipped or duplicated.
- `jumpif`=1, `jumpaddr`=32'h0000_0103 while a fetch is in WAIT:
  - Stale response is discarded.
  - Next valid `if_id_pc`=32'h0000_0100.
  - Exactly 2 bubbles.
- `jumpif`=1 together with `stall`=1: no redirect and IF/ID unchanged. Repeated with `stall`=0 next cycle: redirect occurs.
- Memory with 3-cycle rvalid latency: `imem_req` is low during the wait, exactly one outstanding request, and `if_id_valid` pulses once per 4 cycles.
- Assert `rst` mid-WAIT, then release: `imem_addr`=`RESET_PC`, `if_id_valid`=0, fetch restarts cleanly.
